xor_serial_arbiter: RTL and testbench

- Shares one bit-serial XOR resource between two requesters. The resource is a single instance of the 1-bit NOR-only XOR cell, xor_nor.
- Each requester presents two WIDTH-bit operands. The block grants requesters round-robin, feeds the operands through the shared cell one bit per clock (LSB first), and returns the WIDTH-bit XOR result with a one-cycle done pulse.
- Sits between the requester logic and the xor_nor datapath cell. It is the only block permitted to drive that cell.

---
 rtl/xor_serial_arbiter.sv | 178 +++++++++++++++++
 tb/tb_xor_serial_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_serial_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xor_serial_arbiter (with datapath cell xor_nor)
// Description : Round-robin arbiter sharing one bit-serial NOR-only XOR cell
//               between two requesters. Operands are shifted LSB first
//               through the single cell. The WIDTH-bit result is returned
//               with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================

// 1-bit XOR built only from NOR gates.
module xor_nor (
  input  logic a,
  input  logic b,
  output logic y
);

  logic w_n_ab;
  logic w_n_a;
  logic w_n_b;
  logic w_xnor;

  assign w_n_ab = ~(a | b);
  assign w_n_a  = ~(a | w_n_ab);
  assign w_n_b  = ~(b | w_n_ab);
  assign w_xnor = ~(w_n_a | w_n_b);
  assign y      = ~(w_xnor | w_xnor);

endmodule

module xor_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result0,
  output logic [WIDTH-1:0] result1
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [1:0]         r_state;
  logic               r_owner;       // 0 = requester 0, 1 = requester 1
  logic               r_last_owner;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result0;
  logic [WIDTH-1:0]   r_result1;

  logic               w_y;
  logic               w_win;
  logic               w_start;
  logic               w_shift_en;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_next;

  // On a tie the requester that did not own the resource last time wins.
  assign w_win      = (req0 && req1) ? ~r_last_owner : req1;
  assign w_start    = (r_state == c_idle) && (req0 || req1);
  assign w_shift_en = (r_state == c_shift);
  assign w_last     = w_shift_en && (r_cnt == c_cnt_last);

  // The one and only XOR evaluation point for operand bits.
  xor_nor u_xor_nor (
    .a (r_sa[0]),
    .b (r_sb[0]),
    .y (w_y)
  );

  // The accumulator keeps only the bits that survive to the next shift;
  // the bit that would drop off the LSB end is never observed.
  generate
    if (WIDTH > 1) begin : g_acc_multi
      logic [WIDTH-2:0] r_acc;

      // Shift each new cell output in at the MSB end.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_shift_en) begin
          r_acc <= w_acc_next[WIDTH-1:1];
        end
      end

      assign w_acc_next = {w_y, r_acc};
    end else begin : g_acc_single
      assign w_acc_next = w_y;
    end
  endgenerate

  // Sequencing: arbitrate in IDLE, count WIDTH shifts, one DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_idle;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_start) begin
            r_owner <= w_win;
            r_state <= c_shift;
          end
        end
        c_shift: begin
          if (w_last) begin
            r_last_owner <= r_owner;
            r_state      <= c_done;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Operand capture at grant, then right shifts feeding the cell LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_sa  <= w_win ? a1 : a0;
      r_sb  <= w_win ? b1 : b0;
      r_cnt <= '0;
    end else if (w_shift_en) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Publish the finished word to the owner's result on the final shift only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result0 <= '0;
      r_result1 <= '0;
    end else if (w_last) begin
      if (r_owner) begin
        r_result1 <= w_acc_next;
      end else begin
        r_result0 <= w_acc_next;
      end
    end
  end

  assign busy    = (r_state != c_idle);
  assign gnt     = busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign done0   = (r_state == c_done) && !r_owner;
  assign done1   = (r_state == c_done) &&  r_owner;
  assign result0 = r_result0;
  assign result1 = r_result1;

endmodule
`default_nettype wire

// File: tb/tb_xor_serial_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_serial_arbiter
// Description : Directed, table-driven bench for xor_serial_arbiter
//               (WIDTH=8 instance plus a WIDTH=1 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_serial_arbiter;

  localparam int W = 8;

  typedef struct {
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, done0, done1;
  logic [W-1:0] result0, result1;

  logic         w1_req0;
  logic [0:0]   w1_a0, w1_b0;
  logic [1:0]   w1_gnt;
  logic         w1_busy, w1_done0, w1_done1;
  logic [0:0]   w1_result0, w1_result1;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] res0_m, res1_m;
  vec_t         vecs [6];

  always #5 clk = ~clk;

  xor_serial_arbiter #(.WIDTH(W)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .req0 (req0), .a0 (a0), .b0 (b0),
    .req1 (req1), .a1 (a1), .b1 (b1),
    .gnt (gnt), .busy (busy), .done0 (done0), .done1 (done1),
    .result0 (result0), .result1 (result1)
  );

  xor_serial_arbiter #(.WIDTH(1)) u_dut_w1 (
    .clk (clk), .rst_n (rst_n),
    .req0 (w1_req0), .a0 (w1_a0), .b0 (w1_b0),
    .req1 (1'b0), .a1 (1'b0), .b1 (1'b0),
    .gnt (w1_gnt), .busy (w1_busy), .done0 (w1_done0), .done1 (w1_done1),
    .result0 (w1_result0), .result1 (w1_result1)
  );

  // Single comparison point for the whole bench.
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; w1_req0 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res0_m = '0;
    res1_m = '0;
  endtask

  // One isolated operation; operands are scrambled right after the grant.
  task automatic run_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string nm);
    int           done_at;
    int           gnt_bad;
    int           other_done;
    logic [1:0]   g_exp;
    logic [W-1:0] other;
    g_exp      = sel ? 2'b10 : 2'b01;
    other      = sel ? res0_m : res1_m;
    done_at    = 0;
    gnt_bad    = 0;
    other_done = 0;
    @(negedge clk);
    if (sel) begin a1 = a; b1 = b; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; req0 = 1'b1; end
    for (int c = 1; c <= W + 4 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'hFF; b0 = 8'h00; a1 = 8'hFF; b1 = 8'h00;
      end
      if (gnt !== g_exp) gnt_bad++;
      if (sel ? done0 : done1) other_done++;
      if (sel ? done1 : done0) done_at = c;
    end
    check({nm, "_latency"}, done_at, W + 1);
    check({nm, "_gnt_hold"}, gnt_bad, 0);
    check({nm, "_other_done"}, other_done, 0);
    check({nm, "_result"}, sel ? result1 : result0, exp);
    check({nm, "_other_result"}, sel ? result0 : result1, other);
    @(negedge clk);
    check({nm, "_idle"}, {gnt, busy, done0, done1}, 5'b0);
    if (sel) res1_m = exp; else res0_m = exp;
  endtask

  task automatic run_w1(input logic a, input logic b, input logic exp, input string nm);
    int done_at;
    int pulses;
    done_at = 0;
    pulses  = 0;
    @(negedge clk);
    w1_a0 = a; w1_b0 = b; w1_req0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({nm, "_gnt"}, w1_gnt, 2'b01);
        w1_req0 = 1'b0;
        w1_a0 = ~a; w1_b0 = b;
      end
      if (w1_done0) begin
        pulses++;
        if (done_at == 0) done_at = c;
      end
    end
    check({nm, "_latency"}, done_at, 2);
    check({nm, "_pulses"}, pulses, 1);
    check({nm, "_result"}, w1_result0, exp);
  endtask

  initial begin
    int k, d0cnt, d1cnt, done_at, stray;

    vecs[0] = '{1'b0, 8'hA5, 8'h3C, 8'h99};
    vecs[1] = '{1'b1, 8'h55, 8'h55, 8'h00};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 8'h12, 8'h34, 8'h26};
    vecs[4] = '{1'b0, 8'h80, 8'h01, 8'h81};
    vecs[5] = '{1'b1, 8'hC3, 8'h3C, 8'hFF};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    w1_req0 = 1'b0; w1_a0 = '0; w1_b0 = '0;
    res0_m = '0; res1_m = '0;

    #1;
    check("reset_outputs", {gnt, busy, done0, done1}, 5'b0);
    check("reset_results", {result0, result1}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Isolated operations from the vector table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a shift: no done, results cleared, request retried.
    @(negedge clk);
    a0 = 8'h0F; b0 = 8'hF0; req0 = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_busy_before", gnt, 2'b01);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {gnt, busy, done0, done1}, 5'b0);
    check("midrst_results", {result0, result1}, 16'h0);
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done0 || done1 || busy) stray++;
    end
    check("midrst_quiet", stray, 0);
    rst_n = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 14 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) req0 = 1'b0;
      if (done0) done_at = c;
    end
    check("midrst_retry_latency", done_at, W + 1);
    check("midrst_retry_result0", result0, 8'hFF);
    check("midrst_retry_result1", result1, 8'h00);

    // Both requests held: tie goes to req0, then strict alternation.
    reset_dut();
    @(negedge clk);
    a0 = 8'hFF; b0 = 8'hFF; a1 = 8'hF0; b1 = 8'h0F;
    req0 = 1'b1; req1 = 1'b1;
    k = 0; d0cnt = 0; d1cnt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done0) d0cnt++;
      if (done1) d1cnt++;
      if (done0 || done1) begin
        if (k < 4) begin
          check("alt_order", {done1, done0}, (k % 2) ? 2'b10 : 2'b01);
          check("alt_time", c, 9 + 10 * k);
          check("alt_result0", result0, 8'h00);
          check("alt_result1", result1, (k >= 1) ? 8'hFF : 8'h00);
        end
        k++;
        if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("alt_ops", k, 4);
    check("alt_done0_cycles", d0cnt, 2);
    check("alt_done1_cycles", d1cnt, 2);

    // Single-bit build.
    run_w1(1'b1, 1'b0, 1'b1, "w1_op0");
    run_w1(1'b1, 1'b1, 1'b0, "w1_op1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
